// File: rtl/sensor_cond_pkg.sv
// Shared constants and types for the sensor conditioning block.
// Holds the production defaults and the reduced FAST_SIM timer widths.
package sensor_cond_pkg;
  localparam int ADC_W = 12;
  typedef logic [ADC_W-1:0] adc_t;

  localparam int   SMPL_W_DEF     = 16;
  localparam int   CAD_W_DEF      = 22;
  localparam int   CURR_SHIFT_DEF = 2;
  localparam int   TORQ_SHIFT_DEF = 5;
  localparam adc_t BATT_THRES_DEF = 12'hA98;
  localparam adc_t BATT_HYST_DEF  = 12'h040;

  // FAST_SIM set: short sample and cadence timers for simulation
  localparam int FAST_SMPL_W = 4;
  localparam int FAST_CAD_W  = 12;
endpackage

// File: rtl/sensor_cond_if.sv
// A2D-side readings into the conditioner and conditioned results out.
// master = A2D/consumer side, slave = sensor_cond.
interface sensor_cond_if;
  import sensor_cond_pkg::*;

  adc_t       batt;
  adc_t       curr;
  adc_t       torque;
  logic       cadence_raw;
  adc_t       avg_curr;
  adc_t       avg_torque;
  logic [7:0] cadence_per;
  logic       not_pedaling;
  logic       batt_low;

  modport master (
    output batt, curr, torque, cadence_raw,
    input  avg_curr, avg_torque, cadence_per, not_pedaling, batt_low
  );

  modport slave (
    input  batt, curr, torque, cadence_raw,
    output avg_curr, avg_torque, cadence_per, not_pedaling, batt_low
  );
endinterface

// File: rtl/sensor_cond_ema_filt.sv
// Exponential moving average acc += din - acc/2^SHIFT, with optional preload.
// dout is registered from the updated accumulator so it tracks on the enable edge.
module ema_filt
  import sensor_cond_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  adc_t din,
  output adc_t dout
);
  localparam int ACC_W = ADC_W + SHIFT;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;

  // Steady state is acc = din<<SHIFT, so ACC_W bits never overflow.
  function automatic logic [ACC_W-1:0] ema_step(input logic [ACC_W-1:0] a, input adc_t d);
    return a - (a >> SHIFT) + ACC_W'(d);
  endfunction

  always_comb begin
    acc_nxt = ema_step(acc, din);
    if (load) acc_nxt = {din, {SHIFT{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      dout <= '0;
    end else if (en) begin
      acc  <= acc_nxt;
      dout <= acc_nxt[ACC_W-1 -: ADC_W];
    end
  end
endmodule

// File: rtl/sensor_cond.sv
// Conditions A2D readings: current/torque EMA filters, cadence period
// measurement with not-pedaling detection, and battery-low hysteresis.
module sensor_cond
  import sensor_cond_pkg::*;
#(
  parameter int   SMPL_W     = SMPL_W_DEF,
  parameter int   CAD_W      = CAD_W_DEF,
  parameter int   CURR_SHIFT = CURR_SHIFT_DEF,
  parameter int   TORQ_SHIFT = TORQ_SHIFT_DEF,
  parameter adc_t BATT_THRES = BATT_THRES_DEF,
  parameter adc_t BATT_HYST  = BATT_HYST_DEF
) (
  input logic         clk,
  input logic         rst_n,
  sensor_cond_if.slave sif
);
  localparam logic [ADC_W:0] BATT_CLR = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};

  logic [SMPL_W-1:0] smpl_cnt;
  logic              smpl;
  logic              cad_ff1, cad_ff2, cad_ff3;
  logic              cad_rise;
  logic [CAD_W-1:0]  per_cnt;
  logic              per_sat;
  logic [7:0]        cadence_per_q;
  logic              not_pedaling_q;
  logic              batt_low_q;

  function automatic logic [CAD_W-1:0] sat_inc(input logic [CAD_W-1:0] v);
    return (&v) ? v : v + CAD_W'(1);
  endfunction

  assign smpl     = &smpl_cnt;
  assign per_sat  = &per_cnt;
  assign cad_rise = cad_ff2 & ~cad_ff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smpl_cnt <= '0;
    else        smpl_cnt <= smpl_cnt + SMPL_W'(1);
  end

  // A rise in the same clock as saturation still restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cad_ff1        <= 1'b0;
      cad_ff2        <= 1'b0;
      cad_ff3        <= 1'b0;
      per_cnt        <= '1;
      cadence_per_q  <= 8'hFF;
      not_pedaling_q <= 1'b1;
    end else begin
      cad_ff1        <= sif.cadence_raw;
      cad_ff2        <= cad_ff1;
      cad_ff3        <= cad_ff2;
      not_pedaling_q <= per_sat;
      if (cad_rise) begin
        cadence_per_q <= per_cnt[CAD_W-1 -: 8];
        per_cnt       <= '0;
      end else begin
        per_cnt <= sat_inc(per_cnt);
        if (per_sat) cadence_per_q <= 8'hFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_low_q <= 1'b0;
    end else if (smpl) begin
      if (sif.batt < BATT_THRES)                  batt_low_q <= 1'b1;
      else if ({1'b0, sif.batt} >= BATT_CLR)      batt_low_q <= 1'b0;
    end
  end

  ema_filt #(.SHIFT(CURR_SHIFT)) u_curr_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (smpl),
    .load (1'b0),
    .din  (sif.curr),
    .dout (sif.avg_curr)
  );

  // First rise after a stall preloads so torque tracks immediately.
  ema_filt #(.SHIFT(TORQ_SHIFT)) u_torq_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cad_rise),
    .load (not_pedaling_q),
    .din  (sif.torque),
    .dout (sif.avg_torque)
  );

  assign sif.cadence_per  = cadence_per_q;
  assign sif.not_pedaling = not_pedaling_q;
  assign sif.batt_low     = batt_low_q;
endmodule
